// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: fetch PC register, sequential PC,
// redirect arbitration (branch > return > jump), stall-time redirect capture
// and a small circular return-address stack.
module pc_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned          INSTR_BYTES  = 4,
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pc_write_i,
  input  logic                branch_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  input  logic                call_i,
  input  logic [PC_WIDTH-1:0] call_ret_addr_i,
  input  logic                ret_i,
  output logic [PC_WIDTH-1:0] pc_out_o,
  output logic [PC_WIDTH-1:0] pc_plus_o,
  output logic [PC_WIDTH-1:0] ras_top_o,
  output logic                ras_empty_o,
  output logic                ras_full_o,
  output logic                ras_underflow_o,
  output logic                redirect_pending_o
);

  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  // RAS storage; top_ptr names the most recently pushed entry.
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    top_ptr;
  logic [PTR_W-1:0]    top_inc;
  logic [PTR_W-1:0]    top_dec;
  logic [CNT_W-1:0]    ras_count;

  // Redirect captured while the PC is stalled.
  logic                pend_valid;
  logic [PC_WIDTH-1:0] pend_target;

  logic                ret_eff;
  logic                new_redir;
  logic [PC_WIDTH-1:0] win_target;

  assign pc_plus_o          = pc_out_o + PC_WIDTH'(INSTR_BYTES);
  assign ras_empty_o        = (ras_count == '0);
  assign ras_full_o         = (ras_count == FULL_CNT);
  assign redirect_pending_o = pend_valid;
  // Pointer arithmetic wraps naturally because the depth is a power of two.
  assign top_inc            = top_ptr + PTR_W'(1);
  assign top_dec            = top_ptr - PTR_W'(1);

  // RAS top view, return qualification and redirect arbitration.
  always_comb begin
    ras_top_o  = ras_empty_o ? '0 : ras_mem[top_ptr];
    ret_eff    = ret_i & ~ras_empty_o;
    new_redir  = branch_i | ret_eff | jump_i;
    win_target = jump_target_i;
    if (branch_i) begin
      win_target = branch_target_i;
    end else if (ret_eff) begin
      win_target = ras_top_o;
    end
  end

  // Fetch PC update and stall-time redirect capture.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_out_o    <= RESET_VECTOR;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (pc_write_i) begin
      if (new_redir) begin
        pc_out_o <= win_target;
      end else if (pend_valid) begin
        pc_out_o <= pend_target;
      end else begin
        pc_out_o <= pc_plus_o;
      end
      pend_valid <= 1'b0;
    end else if (new_redir) begin
      // A newer redirect replaces any older one still waiting.
      pend_valid  <= 1'b1;
      pend_target <= win_target;
    end
  end

  // Return-address stack; runs independently of stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      top_ptr         <= '0;
      ras_count       <= '0;
      ras_underflow_o <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      if (ret_i && ras_empty_o) begin
        ras_underflow_o <= 1'b1;
      end
      case ({call_i, ret_eff})
        2'b10: begin
          // When full this overwrites the oldest entry and count saturates.
          ras_mem[top_inc] <= call_ret_addr_i;
          top_ptr          <= top_inc;
          if (!ras_full_o) begin
            ras_count <= ras_count + CNT_W'(1);
          end
        end
        2'b01: begin
          top_ptr   <= top_dec;
          ras_count <= ras_count - CNT_W'(1);
        end
        2'b11: begin
          // Call and return together: replace the top in place.
          ras_mem[top_ptr] <= call_ret_addr_i;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (RESET_VECTOR = 0x100, RAS_DEPTH = 4).
module tb_pc_unit;

  localparam int W     = 32;
  localparam int EXP_W = 2 * W + 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          pc_write_i;
  logic          branch_i;
  logic [W-1:0]  branch_target_i;
  logic          jump_i;
  logic [W-1:0]  jump_target_i;
  logic          call_i;
  logic [W-1:0]  call_ret_addr_i;
  logic          ret_i;
  logic [W-1:0]  pc_out_o;
  logic [W-1:0]  pc_plus_o;
  logic [W-1:0]  ras_top_o;
  logic          ras_empty_o;
  logic          ras_full_o;
  logic          ras_underflow_o;
  logic          redirect_pending_o;

  int checks = 0;
  int errors = 0;

  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic         rst, pw, br;
    logic [W-1:0] bt;
    logic         jp;
    logic [W-1:0] jt;
    logic         call;
    logic [W-1:0] ca;
    logic         ret;
    logic [W-1:0] e_pc, e_top;
    logic         e_empty, e_full, e_uf, e_pend;
  } vec_t;

  vec_t vecs[$];

  pc_unit #(
    .PC_WIDTH    (W),
    .RESET_VECTOR(32'h100),
    .INSTR_BYTES (4),
    .RAS_DEPTH   (4)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .pc_write_i        (pc_write_i),
    .branch_i          (branch_i),
    .branch_target_i   (branch_target_i),
    .jump_i            (jump_i),
    .jump_target_i     (jump_target_i),
    .call_i            (call_i),
    .call_ret_addr_i   (call_ret_addr_i),
    .ret_i             (ret_i),
    .pc_out_o          (pc_out_o),
    .pc_plus_o         (pc_plus_o),
    .ras_top_o         (ras_top_o),
    .ras_empty_o       (ras_empty_o),
    .ras_full_o        (ras_full_o),
    .ras_underflow_o   (ras_underflow_o),
    .redirect_pending_o(redirect_pending_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic pw, input logic br, input logic [W-1:0] bt,
    input logic jp, input logic [W-1:0] jt, input logic call, input logic [W-1:0] ca,
    input logic ret, input logic [W-1:0] e_pc, input logic [W-1:0] e_top,
    input logic e_empty, input logic e_full, input logic e_uf, input logic e_pend);
    vec_t v;
    v.rst = rst; v.pw = pw; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.call = call; v.ca = ca; v.ret = ret; v.e_pc = e_pc; v.e_top = e_top;
    v.e_empty = e_empty; v.e_full = e_full; v.e_uf = e_uf; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver: apply one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    logic [EXP_W-1:0] e;
    logic [W-1:0]     e_pc, e_top;
    rst_i           = v.rst;
    pc_write_i      = v.pw;
    branch_i        = v.br;
    branch_target_i = v.bt;
    jump_i          = v.jp;
    jump_target_i   = v.jt;
    call_i          = v.call;
    call_ret_addr_i = v.ca;
    ret_i           = v.ret;
    exp_q.push_back({v.e_pc, v.e_top, v.e_empty, v.e_full, v.e_uf, v.e_pend});
    @(posedge clk);
    #1;
    e     = exp_q.pop_front();
    e_pc  = e[EXP_W-1 -: W];
    e_top = e[W+3 -: W];
    chk({tag, " pc"},    pc_out_o,  e_pc);
    chk({tag, " plus"},  pc_plus_o, e_pc + 32'd4);
    chk({tag, " top"},   ras_top_o, e_top);
    chk({tag, " empty"}, W'(ras_empty_o),        W'(e[3]));
    chk({tag, " full"},  W'(ras_full_o),         W'(e[2]));
    chk({tag, " uf"},    W'(ras_underflow_o),    W'(e[1]));
    chk({tag, " pend"},  W'(redirect_pending_o), W'(e[0]));
  endtask

  initial begin
    int n;
    logic [W-1:0] pc_exp;

    //              rst pw br bt        jp jt            call ca        ret  pc            top       emp full uf pend
    // Reset, then free-run
    vecs.push_back(mk(0, 1, 0, 0,       0, 0,            0, 0,          0,   32'h100,      0,        1,  0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0,       0, 0,            0, 0,          0,   32'h100,      0,        1,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h104,      0,        1,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h108,      0,        1,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h10C,      0,        1,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h110,      0,        1,  0,  0, 0));
    // Priority: branch beats ret and jump; ret still pops
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'h400,    0,   32'h114,      32'h400,  0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 1, 32'h200, 1, 32'h300,      0, 0,          1,   32'h200,      0,        1,  0,  0, 0));
    // Stall capture, newer redirect overwrites older
    vecs.push_back(mk(1, 0, 0, 0,       1, 32'h500,      0, 0,          0,   32'h200,      0,        1,  0,  0, 1));
    vecs.push_back(mk(1, 0, 1, 32'h600, 0, 0,            0, 0,          0,   32'h200,      0,        1,  0,  0, 1));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h600,      0,        1,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h604,      0,        1,  0,  0, 0));
    // RAS overflow: fifth push overwrites oldest
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hA0,     0,   32'h608,      32'hA0,   0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hA4,     0,   32'h60C,      32'hA4,   0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hA8,     0,   32'h610,      32'hA8,   0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hAC,     0,   32'h614,      32'hAC,   0,  1,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hB0,     0,   32'h618,      32'hB0,   0,  1,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          1,   32'hB0,       32'hAC,   0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          1,   32'hAC,       32'hA8,   0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          1,   32'hA8,       32'hA4,   0,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          1,   32'hA4,       0,        1,  0,  0, 0));
    // Underflow: no redirect, sticky flag
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          1,   32'hA8,       0,        1,  0,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hD0,     0,   32'hAC,       32'hD0,   0,  0,  1, 0));
    // Call + ret together: redirect to old top, top replaced
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hC0,     1,   32'hD0,       32'hC0,   0,  0,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          1,   32'hC0,       0,        1,  0,  1, 0));
    // Call + ret with empty RAS: push only
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            1, 32'hE0,     1,   32'hC4,       32'hE0,   0,  0,  1, 0));
    // Wrap, then reset mid-operation
    vecs.push_back(mk(1, 1, 0, 0,       1, 32'hFFFFFFFC, 0, 0,          0,   32'hFFFFFFFC, 32'hE0,   0,  0,  1, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h0,        32'hE0,   0,  0,  1, 0));
    vecs.push_back(mk(1, 0, 1, 32'h700, 0, 0,            0, 0,          0,   32'h0,        32'hE0,   0,  0,  1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h800, 0, 0,            1, 32'hF0,     0,   32'h100,      0,        1,  0,  0, 0));
    vecs.push_back(mk(1, 1, 0, 0,       0, 0,            0, 0,          0,   32'h104,      0,        1,  0,  0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("row%0d", i));
    end

    // Long stall: redirect and RAS push captured on the first stalled cycle
    n = $urandom_range(2, 5);
    apply(mk(1, 0, 0, 0, 1, 32'h900, 1, 32'h1000, 0, 32'h104, 32'h1000, 0, 0, 0, 1), "stall0");
    for (int i = 1; i < n; i++) begin
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 32'h1000, 0, 0, 0, 1), $sformatf("stall%0d", i));
    end
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h900, 32'h1000, 0, 0, 0, 0), "release");
    // Return while stalled: RAS pops now, redirect waits
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h900, 0, 1, 0, 0, 1), "stall_ret");
    apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 1, 0, 0, 0), "ret_release");

    // Random-length sequential run
    pc_exp = 32'h1000;
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      pc_exp = pc_exp + 32'd4;
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, pc_exp, 0, 1, 0, 0, 0), $sformatf("seq%0d", i));
    end

    chk("queue_drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
